// File: rtl/mipi_tx_frame_sequencer.sv
// Frame sequencer for a MIPI CSI-2 TX: walks VS/VGAP/HS/HGAP/ACT/HEND/VEND phases
// and streams 64-bit words from a first-word-fall-through FIFO onto the TX data path.
module mipi_tx_frame_sequencer #(
  parameter int unsigned H_WORDS   = 480,
  parameter int unsigned V_LINES   = 1080,
  parameter int unsigned HRES_PIX  = 1920,
  parameter logic [5:0]  DATA_TYPE = 6'h2B,
  parameter logic [1:0]  VC_ID     = 2'd0,
  parameter int unsigned VS_CYC    = 4,
  parameter int unsigned VGAP_CYC  = 16,
  parameter int unsigned HS_CYC    = 2,
  parameter int unsigned HGAP_CYC  = 8,
  parameter int unsigned HEND_CYC  = 8,
  parameter int unsigned VEND_CYC  = 16
) (
  input  logic        mipi_pclk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        fifo_empty,
  input  logic [63:0] fifo_data,
  output logic        fifo_rd,
  output logic        tx_vsync,
  output logic        tx_hsync,
  output logic        tx_valid,
  output logic [63:0] tx_data,
  output logic [5:0]  tx_type,
  output logic [15:0] tx_hres,
  output logic [1:0]  tx_vc,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] IDLE = 3'd0;
  localparam logic [ST_W-1:0] VS   = 3'd1;
  localparam logic [ST_W-1:0] VGAP = 3'd2;
  localparam logic [ST_W-1:0] HS   = 3'd3;
  localparam logic [ST_W-1:0] HGAP = 3'd4;
  localparam logic [ST_W-1:0] ACT  = 3'd5;
  localparam logic [ST_W-1:0] HEND = 3'd6;
  localparam logic [ST_W-1:0] VEND = 3'd7;

  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VS_CYC - 1);
  localparam logic [CNT_W-1:0] VGAP_LAST = CNT_W'(VGAP_CYC - 1);
  localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(HS_CYC - 1);
  localparam logic [CNT_W-1:0] HGAP_LAST = CNT_W'(HGAP_CYC - 1);
  localparam logic [CNT_W-1:0] HEND_LAST = CNT_W'(HEND_CYC - 1);
  localparam logic [CNT_W-1:0] VEND_LAST = CNT_W'(VEND_CYC - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(H_WORDS - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_LINES - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic             underflow_q, underflow_d;
  logic             tx_vsync_q, tx_hsync_q, busy_q, frame_done_q;
  logic             tx_valid_q;
  logic [63:0]      tx_data_q;

  logic             fifo_rd_c;
  logic             timed_c;
  logic [CNT_W-1:0] phase_last_c;
  logic             phase_end_c;

  assign fifo_rd_c = (state_q == ACT) & ~fifo_empty & ~i_rst;

  // Length of the current fixed-duration phase; ACT and IDLE are not timed.
  always_comb begin
    timed_c      = 1'b1;
    phase_last_c = '0;
    case (state_q)
      VS:      phase_last_c = VS_LAST;
      VGAP:    phase_last_c = VGAP_LAST;
      HS:      phase_last_c = HS_LAST;
      HGAP:    phase_last_c = HGAP_LAST;
      HEND:    phase_last_c = HEND_LAST;
      VEND:    phase_last_c = VEND_LAST;
      default: timed_c = 1'b0;
    endcase
  end

  assign phase_end_c = timed_c && (phase_q == phase_last_c);

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    word_d      = word_q;
    line_d      = line_q;
    underflow_d = underflow_q;

    if (timed_c) begin
      phase_d = phase_end_c ? '0 : phase_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: if (i_enable) state_d = VS;
      VS:   if (phase_end_c) state_d = VGAP;
      VGAP: if (phase_end_c) state_d = HS;
      HS:   if (phase_end_c) state_d = HGAP;
      HGAP: if (phase_end_c) state_d = ACT;
      ACT: begin
        if (fifo_rd_c) begin
          if (word_q == WORD_LAST) begin
            word_d  = '0;
            state_d = HEND;
          end else begin
            word_d = word_q + CNT_W'(1);
          end
        end else if (fifo_empty && (word_q != '0)) begin
          underflow_d = 1'b1;
        end
      end
      HEND: begin
        if (phase_end_c) begin
          if (line_q == LINE_LAST) begin
            line_d  = '0;
            state_d = VEND;
          end else begin
            line_d  = line_q + CNT_W'(1);
            state_d = HS;
          end
        end
      end
      VEND: if (phase_end_c) state_d = i_enable ? VS : IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_d == VS) && (state_q != VS)) underflow_d = 1'b0;
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge mipi_pclk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      word_q       <= '0;
      line_q       <= '0;
      underflow_q  <= 1'b0;
      tx_vsync_q   <= 1'b0;
      tx_hsync_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      word_q       <= word_d;
      line_q       <= line_d;
      underflow_q  <= underflow_d;
      tx_vsync_q   <= (state_d == VS);
      tx_hsync_q   <= (state_d == HS);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == VEND) && (phase_d == VEND_LAST);
      tx_valid_q   <= fifo_rd_c;
      if (fifo_rd_c) tx_data_q <= fifo_data;
    end
  end

  assign fifo_rd    = fifo_rd_c;
  assign tx_vsync   = tx_vsync_q;
  assign tx_hsync   = tx_hsync_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_type    = DATA_TYPE;
  assign tx_hres    = 16'(HRES_PIX);
  assign tx_vc      = VC_ID;

endmodule

// File: tb/tb_mipi_tx_frame_sequencer.sv
// Directed bench for mipi_tx_frame_sequencer with H_WORDS=4, V_LINES=2 (80-clock frames).
module tb_mipi_tx_frame_sequencer;

  localparam logic [63:0] BASE = 64'hA5C3_0000_0000_1000;

  logic        clk = 1'b0;
  logic        i_rst, i_enable, fifo_empty;
  logic [63:0] fifo_data;
  logic        fifo_rd, tx_vsync, tx_hsync, tx_valid, busy, frame_done, underflow;
  logic [63:0] tx_data;
  logic [5:0]  tx_type;
  logic [15:0] tx_hres;
  logic [1:0]  tx_vc;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int pop_cnt = 0;
  int fd_cnt  = 0;
  logic [63:0] beats[$];

  always #5 clk = ~clk;

  mipi_tx_frame_sequencer #(.H_WORDS(4), .V_LINES(2)) dut (
    .mipi_pclk(clk), .i_rst(i_rst), .i_enable(i_enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .tx_vsync(tx_vsync), .tx_hsync(tx_hsync), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_type(tx_type), .tx_hres(tx_hres), .tx_vc(tx_vc),
    .busy(busy), .frame_done(frame_done), .underflow(underflow)
  );

  // FWFT FIFO model: head word is BASE + number of words already popped.
  assign fifo_data = BASE + 64'(pop_cnt);
  always @(posedge clk) if (fifo_rd) pop_cnt <= pop_cnt + 1;

  always @(negedge clk) begin
    if (tx_valid) beats.push_back(tx_data);
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  typedef struct {
    int   at;
    logic en, emp;
    logic vs, hs, vld, bsy, fd;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  initial begin
    vecs[0]  = '{0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[1]  = '{3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[2]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[3]  = '{20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[4]  = '{21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[5]  = '{22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[6]  = '{30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[7]  = '{31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BASE};
    vecs[8]  = '{34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BASE + 64'd3};
    vecs[9]  = '{35, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[10] = '{42, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[11] = '{53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BASE + 64'd4};
    vecs[12] = '{56, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, BASE + 64'd7};
    vecs[13] = '{57, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};
    vecs[14] = '{79, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd0};
    vecs[15] = '{80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0};

    i_rst = 1'b1; i_enable = 1'b0; fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_data", tx_data, 64'd0);
    chk("rst_type", 64'(tx_type), 64'h2B);
    chk("rst_hres", 64'(tx_hres), 64'd1920);
    chk("rst_vc", 64'(tx_vc), 64'd0);

    // Enable low after reset: must stay idle.
    i_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_vsync", 64'(tx_vsync), 64'd0);

    // Frame 1: FIFO always full, enable held; edge 0 is the first with enable high.
    cyc = -1;
    foreach (vecs[i]) begin
      i_enable   = vecs[i].en;
      fifo_empty = vecs[i].emp;
      goto(vecs[i].at);
      chk($sformatf("v%0d_vsync", i), 64'(tx_vsync), 64'(vecs[i].vs));
      chk($sformatf("v%0d_hsync", i), 64'(tx_hsync), 64'(vecs[i].hs));
      chk($sformatf("v%0d_valid", i), 64'(tx_valid), 64'(vecs[i].vld));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
      chk($sformatf("v%0d_fdone", i), 64'(frame_done), 64'(vecs[i].fd));
      if (vecs[i].vld) chk($sformatf("v%0d_data", i), tx_data, vecs[i].data);
    end

    // Frame 2 (VS at 80): 5-clock stall after the 2nd word of line 1.
    goto(134);
    fifo_empty = 1'b1;
    goto(135);
    chk("uf_set", 64'(underflow), 64'd1);
    chk("uf_stall_valid", 64'(tx_valid), 64'd0);
    goto(139);
    chk("uf_stall_valid_end", 64'(tx_valid), 64'd0);
    fifo_empty = 1'b0;
    goto(141);
    chk("uf_last_beat", 64'(tx_valid), 64'd1);
    goto(142);
    chk("uf_after_line", 64'(tx_valid), 64'd0);
    goto(164);
    chk("uf_held", 64'(underflow), 64'd1);
    chk("uf_fdone", 64'(frame_done), 64'd1);
    goto(165);
    chk("uf_clear_vs", 64'(underflow), 64'd0);
    chk("uf_next_vs", 64'(tx_vsync), 64'd1);

    // Frame 3 (VS at 165): enable dropped mid-frame, frame still completes.
    goto(175);
    i_enable = 1'b0;
    goto(200);
    chk("dis_busy_mid", 64'(busy), 64'd1);
    goto(244);
    chk("dis_fdone", 64'(frame_done), 64'd1);
    goto(245);
    chk("dis_idle_busy", 64'(busy), 64'd0);
    chk("dis_idle_vsync", 64'(tx_vsync), 64'd0);
    goto(250);
    chk("dis_stay_idle", 64'(busy), 64'd0);

    // Frame 4 (VS at 251): reset during ACT of line 0.
    i_enable = 1'b1;
    goto(282);
    chk("rsta_valid", 64'(tx_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("rsta_no_rd", 64'(fifo_rd), 64'd0);
    goto(283);
    chk("rsta_valid0", 64'(tx_valid), 64'd0);
    chk("rsta_busy0", 64'(busy), 64'd0);
    chk("rsta_data0", tx_data, 64'd0);
    chk("rsta_type", 64'(tx_type), 64'h2B);
    goto(284);
    i_rst = 1'b0;
    goto(285);
    chk("rsta_restart", 64'(tx_vsync), 64'd1);

    // Frame 5 (VS at 285): FIFO empty for the first 3 ACT clocks of line 0.
    goto(314);
    fifo_empty = 1'b1;
    goto(315);
    chk("e0_no_rd", 64'(fifo_rd), 64'd0);
    goto(318);
    chk("e0_uf", 64'(underflow), 64'd0);
    chk("e0_valid0", 64'(tx_valid), 64'd0);
    fifo_empty = 1'b0;
    goto(322);
    chk("e0_last_beat", 64'(tx_valid), 64'd1);
    chk("e0_uf_end", 64'(underflow), 64'd0);
    goto(323);
    chk("e0_line_end", 64'(tx_valid), 64'd0);
    goto(330);
    chk("e0_hs_line1", 64'(tx_hsync), 64'd1);
    goto(332);
    chk("e0_hs_end", 64'(tx_hsync), 64'd0);

    // 8+8+8 beats, 1 before the reset abort, 4 on frame 5 line 0; data in pop order.
    chk("beat_count", 64'(beats.size()), 64'd29);
    foreach (beats[i]) chk($sformatf("beat%0d", i), beats[i], BASE + 64'(i));
    chk("fdone_count", 64'(fd_cnt), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mipi_tx_frame_sequencer.md
MIPI_TX_FRAME_SEQUENCER -- requirements
Module: mipi_tx_frame_sequencer

Interface
REQ-001 Parameter H_WORDS, 480: 64-bit data words per active line (range 1..65535).
REQ-002 Parameter V_LINES, 1080: active lines per frame (range 1..65535).
REQ-003 Parameter HRES_PIX, 1920: constant driven on tx_hres.
REQ-004 Parameter DATA_TYPE, 6'h2B: constant driven on tx_type.
REQ-005 Parameter VC_ID, 2'd0: constant driven on tx_vc.
REQ-006 Parameters VS_CYC 4, VGAP_CYC 16, HS_CYC 2, HGAP_CYC 8, HEND_CYC 8, VEND_CYC 16: phase lengths in clocks, each 1..65535.
REQ-007 Clock and reset are fixed: one clock, mipi_pclk; reset i_rst is synchronous and active-high; all ports below are in this single domain.
REQ-008 mipi_pclk  in  1  pixel clock; all state updates on its rising edge.
REQ-009 i_rst  in  1  synchronous active-high reset.
REQ-010 i_enable  in  1  level; run frames while high.
REQ-011 fifo_empty  in  1  upstream first-word-fall-through FIFO empty.
REQ-012 fifo_data  in  64  FIFO head word, valid when fifo_empty=0.
REQ-013 fifo_rd  out  1  pop strobe; combinational.
REQ-014 tx_vsync, tx_hsync, tx_valid  out  1 each  to MIPI TX VSYNC/HSYNC/VALID.
REQ-015 tx_data  out  64  to MIPI TX DATA.
REQ-016 tx_type  out  6; tx_hres  out  16; tx_vc  out  2  constant parameter values.
REQ-017 busy  out  1; frame_done  out  1 (one-clock pulse); underflow  out  1 (sticky per frame).

Function
REQ-018 States: IDLE, VS, VGAP, HS, HGAP, ACT, HEND, VEND; a 16-bit phase counter and 16-bit word and line counters SHALL be used.
REQ-019 IDLE -> VS when i_enable=1; otherwise stay in IDLE.
REQ-020 VS, VGAP, HS, HGAP, HEND and VEND SHALL each last exactly their *_CYC clocks.
REQ-021 Transitions: VS->VGAP->HS->HGAP->ACT->HEND. HEND->HS if lines remain, else ->VEND.
REQ-022 On VEND completion, the block SHALL go to VS if i_enable=1, else to IDLE; i_enable is sampled only at this point and in IDLE, so a frame in progress always completes.
REQ-023 Outputs are Moore-decoded from registered state: tx_vsync=(state==VS), tx_hsync=(state==HS), busy=(state!=IDLE).
REQ-024 fifo_rd = (state==ACT) & ~fifo_empty & ~i_rst.
REQ-025 Each fifo_rd increments the word counter; the fifo_rd for word H_WORDS-1 SHALL move the state to HEND on the next clock.
REQ-026 tx_valid and tx_data are registered: one clock after fifo_rd=1, tx_valid=1 and tx_data=the popped word. Otherwise tx_valid=0 and tx_data holds its last value.
REQ-027 ACT stall: while fifo_empty=1 in ACT, the word counter SHALL hold and tx_valid SHALL be 0; there is no timeout.
REQ-028 underflow SHALL be set when in ACT with fifo_empty=1 and the word counter at nonzero, and SHALL clear on entry to VS.
REQ-029 frame_done SHALL be 1 during the last VEND clock only.
REQ-030 Clock budget per frame with no stall = VS+VGAP+V_LINES*(HS+HGAP+H_WORDS+HEND)+VEND.
REQ-031 tx_type, tx_hres and tx_vc SHALL be constant at all times, including during reset.

Reset
REQ-032 While i_rst=1 at a clock edge: next state=IDLE and all counters=0; tx_valid, tx_vsync, tx_hsync, busy, frame_done and underflow=0; tx_data=0.
REQ-033 Reset mid-frame SHALL abort with no further fifo_rd; after release, the block restarts at VS only if i_enable=1.

Verification (H_WORDS=4, V_LINES=2, other parameters at defaults)
REQ-034 FIFO always full, enable held -> vsync high 4 clocks; 2 hsync pulses of 2 clocks each; 8 tx_valid beats in FIFO order; frame_done once; frame period 80 clocks; next vsync immediately after frame_done.
REQ-035 FIFO empty for 5 clocks after the 2nd word of line 1 -> ACT extends 5 clocks; underflow=1; 4 beats still sent; underflow cleared at next VS.
REQ-036 i_enable dropped mid-frame -> current frame completes; frame_done pulses; then IDLE with busy=0.
REQ-037 i_rst pulsed during ACT of line 0 -> all outputs 0 next clock; no fifo_rd; restart at VS after release with i_enable=1.
REQ-038 FIFO empty at ACT entry for 3 clocks -> underflow stays 0 (word counter 0); line completes normally.
